// File: rtl/ram_bus_sequencer.sv
// Single-word load/store sequencer between the control unit and the 1024x10 RAM.
// Moore FSM: every output is decoded from registered state and latched request fields.
module ram_bus_sequencer #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  input  logic [DATA_W-1:0] bus_in,
  output logic              ram_addr_load,
  output logic              ram_write,
  output logic              ram_read
);

  typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] trk_addr;
  logic              trk_valid;
  logic              accept;
  logic              trk_hit;

  assign accept  = (state == IDLE) && req_valid;
  assign trk_hit = trk_valid && (trk_addr == req_addr);

  // The RAM address register already holds trk_addr, so a hit skips the address phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      trk_addr  <= '0;
      trk_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state == ADDR) begin
        trk_addr  <= lat_addr;
        trk_valid <= 1'b1;
      end
      if (state == READ) begin
        rdata <= bus_in;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    done          = 1'b0;
    bus_out       = '0;
    bus_drive     = 1'b0;
    ram_addr_load = 1'b0;
    ram_write     = 1'b0;
    ram_read      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) begin
          if (trk_hit) state_nxt = req_we ? WRITE : READ;
          else         state_nxt = ADDR;
        end
      end
      ADDR: begin
        bus_drive     = 1'b1;
        bus_out       = DATA_W'(lat_addr);
        ram_addr_load = 1'b1;
        state_nxt     = lat_we ? WRITE : READ;
      end
      WRITE: begin
        bus_drive = 1'b1;
        bus_out   = lat_wdata;
        ram_write = 1'b1;
        state_nxt = RESP;
      end
      READ: begin
        ram_read  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_sequencer.sv
// Directed + random bench for ram_bus_sequencer with a falling-edge RAM model
// and an independent reference memory / address-tracker model.
module tb_ram_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_we;
  logic [9:0] req_addr;
  logic [9:0] req_wdata;
  logic       req_ready;
  logic       done;
  logic [9:0] rdata;
  logic [9:0] bus_out;
  logic       bus_drive;
  logic [9:0] bus_in;
  logic       ram_addr_load;
  logic       ram_write;
  logic       ram_read;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int strobe_viol = 0;

  logic [9:0] ram_mem [1024];
  logic [9:0] ram_ar;
  logic [9:0] ram_dout;
  logic [9:0] ref_mem [1024];
  logic [9:0] ref_trk;
  bit         ref_trk_valid;

  ram_bus_sequencer #(.DATA_W(10), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .done(done), .rdata(rdata), .bus_out(bus_out), .bus_drive(bus_drive),
    .bus_in(bus_in), .ram_addr_load(ram_addr_load), .ram_write(ram_write),
    .ram_read(ram_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM acting at the falling edge, as the real part does.
  assign bus_in = ram_dout;
  always @(negedge clk) begin
    if (ram_addr_load) ram_ar = bus_out;
    if (ram_write) ram_mem[ram_ar] = bus_out;
    if (ram_read) ram_dout = ram_mem[ram_ar];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (int'(ram_addr_load) + int'(ram_write) + int'(ram_read) > 1) strobe_viol++;
      if (bus_drive && ram_read) strobe_viol++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One transaction; returns cycles from accept edge to done and whether ADDR was seen.
  task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [9:0] wdata,
                               input bit hold, output int lat, output bit had_addr,
                               output logic [9:0] rd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = hold;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    lat = 0;
    had_addr = 1'b0;
    rd = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (ram_addr_load) begin
        had_addr = 1'b1;
        checkOutput("addr_bus", bus_out, addr);
        checkOutput("addr_drive", bus_drive, 1);
      end
      if (ram_write) begin
        checkOutput("wdata_bus", bus_out, wdata);
        checkOutput("wdata_drive", bus_drive, 1);
      end
      if (ram_read) checkOutput("read_nodrive", bus_drive, 0);
      if (hold) begin
        checkOutput("hold_ready", req_ready, 0);
        req_addr  = 10'($urandom);
        req_wdata = 10'($urandom);
        if (done) req_valid = 1'b0;
      end
      if (done) begin
        rd = rdata;
        break;
      end
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  int         lat;
  bit         had_addr;
  logic [9:0] rd;
  logic [9:0] prev_rd;
  bit         done_seen;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 10'(i * 7) ^ 10'h155;
      ref_mem[i] = 10'(i * 7) ^ 10'h155;
    end
    ram_ar = '0;
    ram_dout = '0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    ref_trk = '0;
    ref_trk_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_drive", bus_drive, 0);
    checkOutput("rst_bus_out", bus_out, 0);
    checkOutput("rst_strobes", {ram_addr_load, ram_write, ram_read}, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_ready", req_ready, 1);

    applyStimulus(1'b1, 10'h005, 10'h2AB, 1'b0, lat, had_addr, rd);
    checkOutput("st005_addr_phase", had_addr, 1);
    checkOutput("st005_lat", lat, 3);
    checkOutput("st005_rdata_kept", rd, 0);

    applyStimulus(1'b0, 10'h005, 10'h000, 1'b0, lat, had_addr, rd);
    checkOutput("ld005_skip", had_addr, 0);
    checkOutput("ld005_lat", lat, 2);
    checkOutput("ld005_rdata", rd, 10'h2AB);

    applyStimulus(1'b1, 10'h3FF, 10'h001, 1'b0, lat, had_addr, rd);
    checkOutput("st3ff_lat", lat, 3);
    applyStimulus(1'b0, 10'h000, 10'h000, 1'b0, lat, had_addr, rd);
    checkOutput("ld000_addr_phase", had_addr, 1);
    checkOutput("ld000_rdata", rd, 10'h155);
    applyStimulus(1'b0, 10'h3FF, 10'h000, 1'b0, lat, had_addr, rd);
    checkOutput("ld3ff_addr_phase", had_addr, 1);
    checkOutput("ld3ff_lat", lat, 3);
    checkOutput("ld3ff_rdata", rd, 10'h001);

    // Requester holds req_valid with wandering address; only one store may happen.
    applyStimulus(1'b1, 10'h0A0, 10'h1C3, 1'b1, lat, had_addr, rd);
    checkOutput("hold_lat", lat, 3);
    checkOutput("hold_rdata_kept", rd, 10'h001);
    @(negedge clk);
    checkOutput("hold_idle_ready", req_ready, 1);
    checkOutput("hold_no_second", {ram_addr_load, ram_write, ram_read, done}, 0);
    applyStimulus(1'b0, 10'h0A0, 10'h000, 1'b0, lat, had_addr, rd);
    checkOutput("hold_readback", rd, 10'h1C3);
    checkOutput("hold_readback_lat", lat, 2);
    ref_mem[10'h005] = 10'h2AB;
    ref_mem[10'h3FF] = 10'h001;
    ref_mem[10'h0A0] = 10'h1C3;

    // Reset in the middle of a load's READ cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 10'h123;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_addr_phase", ram_addr_load, 1);
    @(negedge clk);
    checkOutput("mid_in_read", ram_read, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_read_drop", ram_read, 0);
    checkOutput("mid_no_drive", bus_drive, 0);
    checkOutput("mid_rdata", rdata, 0);
    done_seen = done;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    checkOutput("mid_no_done", done_seen, 0);
    applyStimulus(1'b0, 10'h123, 10'h000, 1'b0, lat, had_addr, rd);
    checkOutput("mid_reload_addr", had_addr, 1);
    checkOutput("mid_reload_lat", lat, 3);
    checkOutput("mid_reload_rdata", rd, ref_mem[10'h123]);
    ref_trk = 10'h123;
    ref_trk_valid = 1'b1;
    prev_rd = rd;

    for (int n = 0; n < 220; n++) begin
      logic       we;
      logic [9:0] a;
      logic [9:0] d;
      int         exp_lat;
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 9) ? 10'h3FF : 10'($urandom_range(0, 3));
      d  = 10'($urandom_range(0, 1023));
      exp_lat = (ref_trk_valid && ref_trk == a) ? 2 : 3;
      applyStimulus(we, a, d, 1'b0, lat, had_addr, rd);
      checkOutput("rnd_lat", lat, exp_lat);
      if (we) begin
        checkOutput("rnd_st_rdata_kept", rd, prev_rd);
        ref_mem[a] = d;
      end else begin
        checkOutput("rnd_ld_rdata", rd, ref_mem[a]);
        prev_rd = rd;
      end
      ref_trk = a;
      ref_trk_valid = 1'b1;
    end

    checkOutput("strobe_exclusive", strobe_viol, 0);
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
